// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if;
    logic        m0_req;
    logic        m1_req;
    logic        m0_we;
    logic        m1_we;
    logic [31:0] m0_adr;
    logic [31:0] m1_adr;
    logic [31:0] m0_wdata;
    logic [31:0] m1_wdata;
    logic [31:0] m0_rdata;
    logic [31:0] m1_rdata;
    logic        m0_done;
    logic        m1_done;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_adr, m1_adr, m0_wdata, m1_wdata, mem_rdata,
        output m0_rdata, m1_rdata, m0_done, m1_done, mem_en, mem_we, mem_adr, mem_wdata, busy
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_adr, m1_adr, m0_wdata, m1_wdata, mem_rdata,
        input  m0_rdata, m1_rdata, m0_done, m1_done, mem_en, mem_we, mem_adr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin arbiter for a single fixed-latency memory port
module mem_port_arbiter #(
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [3:0] LAT4 = RD_LAT[3:0];

    logic [1:0]  state;
    logic        gnt;
    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] wdata_q;
    logic [3:0]  cnt;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        gnt_next;

    // gnt doubles as the last-grant register: on a tie the other port wins
    always_comb begin
        gnt_next = bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            gnt_next = ~gnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            gnt     <= 1'b1;
            we_q    <= 1'b0;
            adr_q   <= 32'd0;
            wdata_q <= 32'd0;
            cnt     <= 4'd0;
            rdata0  <= 32'd0;
            rdata1  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.m0_req || bus.m1_req) begin
                        gnt     <= gnt_next;
                        we_q    <= gnt_next ? bus.m1_we    : bus.m0_we;
                        adr_q   <= gnt_next ? bus.m1_adr   : bus.m0_adr;
                        wdata_q <= gnt_next ? bus.m1_wdata : bus.m0_wdata;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        state <= RESP;
                    end else begin
                        cnt   <= LAT4;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        if (gnt) begin
                            rdata1 <= bus.mem_rdata;
                        end else begin
                            rdata0 <= bus.mem_rdata;
                        end
                        state <= RESP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = (state == ACCESS);
    assign bus.mem_we    = (state == ACCESS) && we_q;
    assign bus.mem_adr   = adr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.m0_done   = (state == RESP) && !gnt;
    assign bus.m1_done   = (state == RESP) && gnt;
    assign bus.m0_rdata  = rdata0;
    assign bus.m1_rdata  = rdata1;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // memory model: read data is valid only in the cycle RD_LAT after mem_en
    logic [3:0]  mdl_cnt = 4'd0;
    logic [31:0] mdl_adr = 32'd0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h80) ? 32'h12345678 : {a[15:0], 16'hA5A5};
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en && !bus.mem_we) begin
            mdl_cnt <= 4'(RD_LAT);
            mdl_adr <= bus.mem_adr;
        end else if (mdl_cnt != 4'd0) begin
            mdl_cnt <= mdl_cnt - 4'd1;
        end
    end

    assign bus.mem_rdata = (mdl_cnt == 4'd1) ? mem_data(mdl_adr) : 32'hBAD0BAD0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int port, input logic req, input logic we,
                           input logic [31:0] adr, input logic [31:0] wdata);
        if (port == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_adr = adr; bus.m0_wdata = wdata;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_adr = adr; bus.m1_wdata = wdata;
        end
    endtask

    // issue in the current IDLE cycle (cycle 0), expect done in cycle exp_cyc
    task automatic run_txn(input string tag, input int port, input logic we,
                           input logic [31:0] adr, input logic [31:0] wdata, input int exp_cyc);
        int   done_cyc = 0;
        logic other = 1'b0;
        logic en1 = 1'b0;
        logic [31:0] adr1 = 32'd0;
        set_req(port, 1'b1, we, adr, wdata);
        for (int i = 1; i <= 25 && done_cyc == 0; i++) begin
            tick();
            if (i == 1) begin
                en1 = bus.mem_en;
                adr1 = bus.mem_adr;
                check_eq({tag, " mem_we"}, 32'(bus.mem_we), 32'(we));
                if (we) check_eq({tag, " mem_wdata"}, bus.mem_wdata, wdata);
            end
            if ((port == 0) ? bus.m1_done : bus.m0_done) other = 1'b1;
            if ((port == 0) ? bus.m0_done : bus.m1_done) done_cyc = i;
        end
        set_req(port, 1'b0, 1'b0, 32'd0, 32'd0);
        check_eq({tag, " mem_en c1"}, 32'(en1), 32'd1);
        check_eq({tag, " mem_adr c1"}, adr1, adr);
        check_eq({tag, " done_cyc"}, done_cyc, exp_cyc);
        check_eq({tag, " other_done"}, 32'(other), 32'd0);
        if (!we) check_eq({tag, " rdata"}, (port == 0) ? bus.m0_rdata : bus.m1_rdata, mem_data(adr));
        tick();
        check_eq({tag, " done_pulse_end"}, 32'(bus.m0_done | bus.m1_done), 32'd0);
        check_eq({tag, " busy_after"}, 32'(bus.busy), 32'd0);
    endtask

    int dports[4];
    int dcycs[4];
    int nd;

    initial begin
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_eq("rst busy", 32'(bus.busy), 32'd0);
        check_eq("rst mem_en", 32'(bus.mem_en), 32'd0);
        check_eq("rst mem_adr", bus.mem_adr, 32'd0);
        check_eq("rst m0_rdata", bus.m0_rdata, 32'd0);

        run_txn("w0", 0, 1'b1, 32'h40, 32'hDEADBEEF, 2);
        run_txn("r1", 1, 1'b0, 32'h80, 32'd0, RD_LAT + 2);
        check_eq("r1 m0_rdata kept", bus.m0_rdata, 32'd0);
        run_txn("r0", 0, 1'b0, 32'h44, 32'd0, RD_LAT + 2);
        check_eq("r0 m1_rdata kept", bus.m1_rdata, 32'h12345678);

        // reset during WAIT of a port 0 read
        set_req(0, 1'b1, 1'b0, 32'h30, 32'd0);
        tick();
        tick();
        check_eq("abort in wait", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("abort busy", 32'(bus.busy), 32'd0);
        check_eq("abort mem_en", 32'(bus.mem_en), 32'd0);
        check_eq("abort mem_adr", bus.mem_adr, 32'd0);
        check_eq("abort m0_rdata", bus.m0_rdata, 32'd0);
        check_eq("abort m1_rdata", bus.m1_rdata, 32'd0);
        check_eq("abort m0_done", 32'(bus.m0_done), 32'd0);
        tick();
        check_eq("abort m0_done held", 32'(bus.m0_done), 32'd0);
        reset = 1'b1;
        run_txn("reissue", 0, 1'b0, 32'h30, 32'd0, RD_LAT + 2);

        // requester inputs change mid-transaction
        set_req(0, 1'b1, 1'b0, 32'h10, 32'd0);
        tick();
        tick();
        set_req(0, 1'b1, 1'b1, 32'h20, 32'h55555555);
        for (int i = 2; i <= 4; i++) begin
            check_eq($sformatf("hold mem_adr c%0d", i), bus.mem_adr, 32'h10);
            check_eq($sformatf("hold mem_we c%0d", i), 32'(bus.mem_we), 32'd0);
            if (i < 4) tick();
        end
        check_eq("hold m0_done", 32'(bus.m0_done), 32'd1);
        check_eq("hold m0_rdata", bus.m0_rdata, 32'h0010A5A5);
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // both ports requesting continuously after reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_req(0, 1'b1, 1'b1, 32'h100, 32'h0);
        set_req(1, 1'b1, 1'b1, 32'h200, 32'h1);
        nd = 0;
        for (int i = 1; i <= 40 && nd < 4; i++) begin
            tick();
            if (bus.m0_done && bus.m1_done) check_eq("rr both_done", 32'd1, 32'd0);
            if (bus.m0_done || bus.m1_done) begin
                dports[nd] = bus.m1_done ? 1 : 0;
                dcycs[nd] = i;
                nd++;
            end
        end
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        check_eq("rr count", nd, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < nd) begin
                check_eq($sformatf("rr port %0d", k), dports[k], k % 2);
                check_eq($sformatf("rr cyc %0d", k), dcycs[k], 2 + 3 * k);
            end
        end
        tick();
        check_eq("rr busy_after", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
